// File: rtl/signed_addsub_seq_if.sv
// Operand/result bundle between the calculator front-end and the add/sub sequencer.
// Latency: none (wires only).
// Backpressure: none; start is a request pulse, done is a one-cycle completion pulse.
//
// Signals:
//   start     - request pulse, front-end -> sequencer
//   op        - 0 = A+B, 1 = A-B, captured with start
//   a, b      - W-bit two's complement operands, captured with start
//   busy      - sequencer is stepping through bits
//   done      - one-cycle pulse, result/overflow/carry_out just updated
//   result    - W-bit signed sum/difference, held until next completion
//   overflow  - signed overflow of the last completed operation
//   carry_out - carry out of the MSB (for subtract: 1 = no borrow)
interface signed_addsub_seq_if #(
   parameter int W = 8
) ();
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         overflow;
   logic         carry_out;

   modport master (
      output start, op, a, b,
      input  busy, done, result, overflow, carry_out
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, overflow, carry_out
   );
endinterface

// File: rtl/signed_addsub_seq.sv
// Bit-serial signed add/subtract: one full-adder slice reused over W bits, LSB first.
// Latency: W cycles from the start edge to the edge entering DONE; one op per W+1 cycles.
// Backpressure: none; start is ignored while busy, start in the DONE cycle chains directly.
//
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous reset, active low
//   bus - signed_addsub_seq_if slave (start/op/a/b in, busy/done/result/overflow/carry_out out)
module signed_addsub_seq #(
   parameter int W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   signed_addsub_seq_if.slave    bus
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_sr_q, a_sr_d;
   logic [W-1:0]   b_sr_q, b_sr_d;
   // Only W-1 sum bits are ever parked here; the MSB sum bit goes straight
   // into the result on the final step.
   logic [W-2:0]   acc_q, acc_d;
   logic           c_q, c_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   result_q, result_d;
   logic           ovf_q, ovf_d;
   logic           cout_q, cout_d;

   // Full adder built from two half-adder stages plus an OR.
   logic ha1_s, ha1_c, ha2_s, ha2_c, fa_c;
   assign ha1_s = a_sr_q[0] ^ b_sr_q[0];
   assign ha1_c = a_sr_q[0] & b_sr_q[0];
   assign ha2_s = ha1_s ^ c_q;
   assign ha2_c = ha1_s & c_q;
   assign fa_c  = ha1_c | ha2_c;

   logic [W-1:0] acc_shift;
   assign acc_shift = {ha2_s, acc_q};

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      acc_d    = acc_q;
      c_d      = c_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      cout_d   = cout_q;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = RUN;
               a_sr_d  = bus.a;
               // Subtract is A + ~B + 1: invert B here, the +1 is the carry-in.
               b_sr_d  = bus.op ? ~bus.b : bus.b;
               c_d     = bus.op;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            acc_d  = acc_shift[W-1:1];
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            c_d    = fa_c;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               state_d  = DONE;
               result_d = acc_shift;
               // c_q is the carry into the MSB, fa_c the carry out of it.
               ovf_d    = c_q ^ fa_c;
               cout_d   = fa_c;
               cnt_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         acc_q    <= '0;
         c_q      <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         acc_q    <= acc_d;
         c_q      <= c_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         cout_q   <= cout_d;
      end
   end

   assign bus.busy      = (state_q == RUN);
   assign bus.done      = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.overflow  = ovf_q;
   assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_signed_addsub_seq.sv
// Directed + randomized bench for the bit-serial signed add/subtract sequencer.
// Latency: checks W busy cycles then a single done cycle per operation.
// Backpressure: exercises ignored start in RUN and back-to-back start in DONE.
module tb_signed_addsub_seq;

   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;
   localparam int SMAX = (1 << (W - 1)) - 1;
   localparam int SMIN = -(1 << (W - 1));

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   signed_addsub_seq_if #(.W(W)) bus ();

   signed_addsub_seq #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on the two's complement values.
   // Returns {carry_out, overflow, result}.
   function automatic logic [W+1:0] model(input int ua, input int ub, input bit op);
      int sa, sb, full;
      logic          ovf, cout;
      logic [W-1:0]  res;
      sa   = (ua > SMAX) ? ua - (1 << W) : ua;
      sb   = (ub > SMAX) ? ub - (1 << W) : ub;
      full = op ? sa - sb : sa + sb;
      res  = W'(full & MASK);
      ovf  = (full > SMAX) || (full < SMIN);
      cout = op ? (ua >= ub) : ((ua + ub) > MASK);
      return {cout, ovf, res};
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
   endtask

   // Issues one operation, checks W busy cycles, then the done cycle.
   // Returns positioned in the DONE cycle. glitch >= 0 pulses a bogus start
   // during that RUN cycle index (0-based).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic op, input int glitch);
      logic [W+1:0] e;
      e = model(int'(a), int'(b), op);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.op    = op;
      step();
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.op    = 1'($urandom);
      for (int i = 0; i < W; i++) begin
         if (i == glitch) begin
            bus.start = 1'b1;
            bus.a     = W'(1);
            bus.b     = W'(1);
            bus.op    = 1'b0;
         end
         check("busy_run", 32'(bus.busy), 32'd1);
         check("done_in_run", 32'(bus.done), 32'd0);
         step();
         bus.start = 1'b0;
      end
      check("done_pulse", 32'(bus.done), 32'd1);
      check("busy_in_done", 32'(bus.busy), 32'd0);
      check("result", 32'(bus.result), 32'(e[W-1:0]));
      check("overflow", 32'(bus.overflow), 32'(e[W]));
      check("carry_out", 32'(bus.carry_out), 32'(e[W+1]));
   endtask

   task automatic idle_step();
      bus.start = 1'b0;
      step();
      check_idle_outputs("after_done");
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      // Reset state
      rst = 1'b0;
      step();
      step();
      check_idle_outputs("reset");
      check("reset_result", 32'(bus.result), 32'd0);
      check("reset_ovf", 32'(bus.overflow), 32'd0);
      check("reset_cout", 32'(bus.carry_out), 32'd0);
      rst = 1'b1;
      step();

      // Directed arithmetic cases
      run_op(8'd100, 8'd27, 1'b0, -1);
      check("t1_result_const", 32'(bus.result), 32'h7F);
      idle_step();
      run_op(8'd100, 8'd28, 1'b0, -1);
      check("t2_ovf_const", 32'(bus.overflow), 32'd1);
      idle_step();
      run_op(8'h80, 8'd1, 1'b1, -1);
      check("t2b_result_const", 32'(bus.result), 32'h7F);
      idle_step();
      run_op(8'd5, 8'd7, 1'b1, -1);
      check("t3_result_const", 32'(bus.result), 32'hFE);
      idle_step();
      run_op(8'hFF, 8'hFF, 1'b0, -1);
      check("t3b_cout_const", 32'(bus.carry_out), 32'd1);
      idle_step();
      run_op(8'd0, 8'h80, 1'b1, -1);
      idle_step();
      run_op(8'd0, 8'd0, 1'b1, -1);
      idle_step();

      // Start during RUN is ignored; only one done follows
      run_op(8'd10, 8'd20, 1'b0, 2);
      check("t4_result_const", 32'(bus.result), 32'd30);
      for (int i = 0; i < 12; i++) begin
         step();
         check_idle_outputs("t4_no_second_done");
      end

      // Reset mid-operation discards the partial result
      bus.start = 1'b1;
      bus.a     = 8'd50;
      bus.b     = 8'd50;
      bus.op    = 1'b0;
      step();
      bus.start = 1'b0;
      step();
      step();
      step();
      check("t5_busy_before_rst", 32'(bus.busy), 32'd1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check_idle_outputs("t5_reset");
      check("t5_result", 32'(bus.result), 32'd0);
      check("t5_ovf", 32'(bus.overflow), 32'd0);
      check("t5_cout", 32'(bus.carry_out), 32'd0);
      for (int i = 0; i < 12; i++) begin
         step();
         check_idle_outputs("t5_no_done");
         check("t5_result_hold", 32'(bus.result), 32'd0);
      end

      // Back-to-back: start held in the DONE cycle
      run_op(8'd3, 8'd4, 1'b0, -1);
      check("t6_first_const", 32'(bus.result), 32'd7);
      run_op(8'hFD, 8'd4, 1'b1, -1);
      check("t6_second_const", 32'(bus.result), 32'hF9);
      idle_step();

      // Randomized operations, mixing idle gaps and back-to-back chains
      for (int n = 0; n < 60; n++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = W'($urandom);
         if (n % 7 == 0) rb = 8'h80;
         if (n % 11 == 0) ra = 8'h7F;
         run_op(ra, rb, 1'($urandom), -1);
         if ($urandom_range(0, 1) == 0) idle_step();
      end
      idle_step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/signed_addsub_seq.md
Name: signed_addsub_seq

Overview:
- Bit-serial signed add/subtract sequencer for the gate-level calculator.
- Time-shares a single 1-bit full-adder slice, built from two half-adder stages plus an OR, across all W bit positions, LSB first, one bit per clock.
- Owns operand and result shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake.
- Sits between the calculator front-end, which issues operands and opcode, and the result display/register stage.

Parameters:
W  8  operand/result width in bits, two's complement; legal range W >= 2.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous reset, active-low: rst=0 at a rising clk edge resets all state.
start  input  1  request pulse; sampled only in IDLE or DONE.
op  input  1  0 = A+B, 1 = A-B; captured with start.
a  input  W  signed operand A; captured with start.
b  input  W  signed operand B; captured with start.
busy  output  1  high while bits are being processed (RUN).
done  output  1  one-cycle pulse: result, overflow and carry_out are valid and updated.
result  output  W  signed sum/difference; holds its value until the next completion or reset.
overflow  output  1  signed overflow of the last completed operation.
carry_out  output  1  carry out of the MSB. For subtract, 1 means no borrow.

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE.
  - busy=0, done=0, result=0, overflow=0, carry_out=0.
  - Bit counter, carry FF and shift registers are cleared.
  - Reset overrides start and any in-flight operation; a partial result is discarded and never reaches result.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN.
  - Latch A into a_sr.
  - Latch B into b_sr, or ~B when op=1.
  - Carry FF := op, so subtract gets carry-in 1.
  - count := 0.
- RUN, each edge:
  - s = a_sr[0]^b_sr[0]^c.
  - c' = a_sr[0]&b_sr[0] | c&(a_sr[0]^b_sr[0]).
  - Shift s into the MSB of the accumulator, right-shifting it; right-shift a_sr and b_sr; carry FF := c'.
  - On the MSB step (count=W-1), also capture carry-in-to-MSB (the old carry FF) and carry-out (c').
  - count increments each edge. At count=W-1 the edge completes the last bit and goes → DONE.
- DONE, one cycle:
  - done=1 and busy=0.
  - result = accumulator, updated on the edge entering DONE.
  - overflow = carry_into_msb XOR carry_out.
  - start=1 in DONE → RUN directly, with the same capture as in IDLE (back-to-back supported); otherwise → IDLE.
- Timing:
  - start sampled at edge t0.
  - busy=1 after edges t0 … t0+W-1.
  - done=1 for exactly the cycle after edge t0+W.
  - Latency is W cycles; throughput is one operation per W+1 cycles.
- start in RUN is ignored, with no queuing. a, b and op may change freely after the capture edge.
- Arithmetic is modulo 2^W; result wraps on overflow and overflow flags it.
- op=1 with B = -2^(W-1): ~B+1 is computed natively in-stream. Overflow is flagged correctly by the carry rule, with no special case.
- done and busy are never high simultaneously.
- result, overflow and carry_out change only on the edge into DONE or on reset.

Test Plan:
1. W=8, reset then start with a=100, b=27, op=0.
   - busy high for 8 cycles.
   - done one cycle later: result=0x7F (127), overflow=0, carry_out=0.
2. a=100, b=28, op=0 → result=0x80 (-128), overflow=1, carry_out=0.
   - Also a=-128 (0x80), b=1, op=1 → result=0x7F, overflow=1, carry_out=1.
3. a=5, b=7, op=1 → result=0xFE (-2), overflow=0, carry_out=0.
   - Also a=-1 (0xFF), b=-1, op=0 → result=0xFE, overflow=0, carry_out=1.
4. Start a=10, b=20, op=0.
   - Pulse start with a=1, b=1 in RUN cycle 3: ignored.
   - done once after 8 cycles with result=30. No second done follows.
5. Start a=50, b=50, op=0; drive rst=0 at RUN cycle 4 for one edge.
   - Next cycle: busy=0, done=0, result=0, overflow=0, carry_out=0, state IDLE.
   - No done pulse afterwards.
6. Back-to-back: start (3+4) completes.
   - Hold start=1 in the DONE cycle with a=-3, b=4, op=1.
   - First done: result=7.
   - busy immediately after, for 8 cycles.
   - Second done: result=0xF9 (-7), overflow=0.
